// File: rtl/watch_date_bcd.sv
// watch_date_bcd
// ----------------------------------------------------------------------------
// Sequential binary-to-BCD converter for the watch calendar/time fields.
// The six fields are snapshotted on a start-accept edge. Each field is then
// converted one bit per clock with the shift/add-3 (double-dabble) method.
// The 14-digit result is handed off with a valid/ready handshake.
//
// Handshake: bcd_date is meaningful only while out_valid is high. The result
// is held stable until out_valid && out_ready is sampled at a rising edge.
// On that edge it is consumed.
//
// Parameters:
//   AUTO_RUN  0: only start begins a conversion.
//             1: IDLE always begins a conversion and start is ignored. The
//                next conversion therefore follows each handshake directly.
// Optional build macro:
//   WATCH_BCD_BLANK_EN  leading zero year digits (Y3..Y1) are output as 4'hF.
//                       Y0 and the other fields are never blanked.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   start      conversion request, acted on only in IDLE
//   year       12-bit binary year
//   month      4-bit binary month
//   day        5-bit binary day
//   hour       5-bit binary hour
//   minute     6-bit binary minute
//   second     6-bit binary second
//   busy       high whenever the FSM is not in IDLE
//   out_valid  bcd_date holds a completed result
//   out_ready  consumer accepts the result
//   bcd_date   {Y3,Y2,Y1,Y0,Mo1,Mo0,D1,D0,H1,H0,Mi1,Mi0,S1,S0}
// ----------------------------------------------------------------------------
module watch_date_bcd #(
    parameter int AUTO_RUN = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] year,
    input  logic [3:0]  month,
    input  logic [4:0]  day,
    input  logic [4:0]  hour,
    input  logic [5:0]  minute,
    input  logic [5:0]  second,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [55:0] bcd_date
);

    typedef enum logic [1:0] {IDLE, CONV, STORE, VALID} state_t;
    state_t state;

    // The year snapshot lives directly in the bit shifter, because year is
    // the first field converted. The other fields wait in their own registers.
    logic [3:0]  s_month;
    logic [4:0]  s_day;
    logic [4:0]  s_hour;
    logic [5:0]  s_minute;
    logic [5:0]  s_second;

    logic [2:0]  fld;      // 0 year, 1 month, 2 day, 3 hour, 4 minute, 5 second
    logic [3:0]  cnt;      // bits of the current field still to shift in
    logic [15:0] scratch;  // BCD accumulator, up to 4 digits
    logic [11:0] bits;     // current field, MSB-aligned at bit 11

    logic        go;
    logic [15:0] adj;
    logic [11:0] nxt_bits;
    logic [3:0]  nxt_width;
    logic [15:0] year_digits;

    assign go = (AUTO_RUN != 0) ? 1'b1 : start;

    // Add 3 to every digit >= 5, so the next shift carries correctly into
    // the digit above.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Load value for the field after the current one. Fields are MSB-aligned
    // so the shifter always takes bit 11.
    always_comb begin
        nxt_bits  = '0;
        nxt_width = 4'd4;
        case (fld)
            3'd0: begin nxt_bits = {s_month,  8'd0}; nxt_width = 4'd4; end
            3'd1: begin nxt_bits = {s_day,    7'd0}; nxt_width = 4'd5; end
            3'd2: begin nxt_bits = {s_hour,   7'd0}; nxt_width = 4'd5; end
            3'd3: begin nxt_bits = {s_minute, 6'd0}; nxt_width = 4'd6; end
            3'd4: begin nxt_bits = {s_second, 6'd0}; nxt_width = 4'd6; end
            default: begin nxt_bits = '0; nxt_width = 4'd4; end
        endcase
    end

`ifdef WATCH_BCD_BLANK_EN
    // Blank leading zeros of the year from the top digit down. Stop at the
    // first nonzero digit. Y0 always shows.
    always_comb begin
        year_digits = scratch;
        if (scratch[15:12] == 4'd0) begin
            year_digits[15:12] = 4'hF;
            if (scratch[11:8] == 4'd0) begin
                year_digits[11:8] = 4'hF;
                if (scratch[7:4] == 4'd0) begin
                    year_digits[7:4] = 4'hF;
                end
            end
        end
    end
`else
    assign year_digits = scratch;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            bcd_date  <= '0;
            s_month   <= '0;
            s_day     <= '0;
            s_hour    <= '0;
            s_minute  <= '0;
            s_second  <= '0;
            fld       <= '0;
            cnt       <= '0;
            scratch   <= '0;
            bits      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        bits     <= year;
                        s_month  <= month;
                        s_day    <= day;
                        s_hour   <= hour;
                        s_minute <= minute;
                        s_second <= second;
                        fld      <= 3'd0;
                        cnt      <= 4'd12;
                        scratch  <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    scratch <= {adj[14:0], bits[11]};
                    bits    <= {bits[10:0], 1'b0};
                    cnt     <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= STORE;
                    end
                end
                STORE: begin
                    case (fld)
                        3'd0:    bcd_date[55:40] <= year_digits;
                        3'd1:    bcd_date[39:32] <= scratch[7:0];
                        3'd2:    bcd_date[31:24] <= scratch[7:0];
                        3'd3:    bcd_date[23:16] <= scratch[7:0];
                        3'd4:    bcd_date[15:8]  <= scratch[7:0];
                        default: bcd_date[7:0]   <= scratch[7:0];
                    endcase
                    if (fld == 3'd5) begin
                        out_valid <= 1'b1;
                        state     <= VALID;
                    end else begin
                        fld     <= fld + 3'd1;
                        cnt     <= nxt_width;
                        bits    <= nxt_bits;
                        scratch <= '0;
                        state   <= CONV;
                    end
                end
                VALID: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/watch_date_bcd.md
Name: watch_date_bcd

Overview:
- Sequential binary-to-BCD converter that reads the watch's binary calendar/time fields (year, month, day, hour, minute, second) and produces a 14-digit packed BCD word for the display/readout path.
- Works on the consumer side of the date counter's outputs, one bit per cycle using the shift/add-3 (double-dabble) method, and hands the result off with a valid/ready handshake.

Parameters:
- AUTO_RUN, 0, when 1 a new conversion starts automatically in the cycle after each output handshake completes, and `start` is ignored; when 0 only `start` begins a conversion.

Ports:
- clk  input  1  the single clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request a conversion; acted on only in IDLE.
- year  input  12  binary year, 0..4095.
- month  input  4  binary month.
- day  input  5  binary day.
- hour  input  5  binary hour.
- minute  input  6  binary minute.
- second  input  6  binary second.
- busy  output  1  high whenever the FSM is not in IDLE.
- out_valid  output  1  bcd_date holds a completed result.
- out_ready  input  1  consumer accepts the result.
- bcd_date  output  56  digits, MSB first, 4 bits per digit: {Y3,Y2,Y1,Y0, Mo1,Mo0, D1,D0, H1,H0, Mi1,Mi0, S1,S0}.

Behaviour:
- Reset: rst high at a clock edge forces state IDLE, and clears busy, out_valid, bcd_date, all snapshot registers, the field index and the bit counter to 0. Reset mid-conversion abandons the conversion; no partial result is ever presented.
- FSM states: IDLE, CONV, STORE, VALID.
- IDLE:
  - A start edge (start=1, or AUTO_RUN=1 following a handshake) snapshots all six inputs.
  - Field index is set to 0 (year), the bit counter is loaded with the field width (12), and the BCD scratch register is cleared.
  - Next state is CONV.
  - Inputs that change after the snapshot do not affect the result.
- CONV:
  - Each cycle, every scratch nibble that is ≥5 has 3 added to it.
  - Then {scratch, field bits} shifts left by 1, bringing in the field MSB, and the bit counter decrements.
  - When the counter reaches 0 after the shift, the next state is STORE.
- STORE (1 cycle):
  - Scratch digits are written into the field's slot in bcd_date: year uses 4 digits, every other field uses 2.
  - If the field index is 5, the next state is VALID and out_valid goes high on that same edge.
  - Otherwise the field index increments, the counter is loaded with the next width (4, 5, 5, 6, 6), the scratch is cleared, and the next state is CONV.
- Latency: out_valid rises exactly 44 clock edges after the start-accept edge (38 CONV + 6 STORE).
- VALID:
  - bcd_date and out_valid stay stable until out_valid && out_ready is sampled at an edge.
  - On that edge out_valid falls and the state returns to IDLE.
  - out_ready high while in IDLE, CONV or STORE has no effect.
- start:
  - start while busy is ignored and not queued.
  - start during VALID is ignored; the block must be back in IDLE to accept it.
  - With AUTO_RUN=1 the IDLE cycle after a handshake begins the next conversion.
- Out-of-range inputs are converted literally, with no clamping or error signalling: month 15 → "15", hour 31 → "31", minute 63 → "63". Year 4095 → "4095".
- bcd_date keeps its last value outside VALID until the STOREs of the next conversion overwrite it field by field. Consumers must sample it only when out_valid is high.
- Simultaneous rst with start or out_ready: rst wins.

Optional Feature:
- Macro: WATCH_BCD_BLANK_EN.
- Defined: leading zero digits of the year (Y3, then Y2, then Y1, scanning from the MSB until the first nonzero digit) are output as 4'hF (blank code) instead of 4'h0. Y0 is never blanked, and the month/day/hour/minute/second digits are never blanked. Blanking is applied in the year STORE cycle, so latency is unchanged.
- Undefined: all digits are plain BCD, leading zeros included.

Test Plan:
- Reset, then start with year=2024, month=3, day=15, hour=9, minute=5, second=59, out_ready=1 → out_valid rises 44 edges later with bcd_date = 0x2024_03_15_09_05_59; busy falls after the handshake edge.
- year=4095, month=12, day=31, hour=23, minute=59, second=59 → bcd_date = 0x4095_12_31_23_59_59.
- Hold out_ready=0 for 10 cycles after out_valid → bcd_date and out_valid stay stable; start pulses during CONV and VALID are ignored; raise out_ready → one handshake, back to IDLE.
- Start a conversion, change the inputs to all zeros on the next cycle → the result still matches the snapshot; assert rst at cycle 20 → out_valid=0, busy=0, bcd_date=0 on the following cycle, and no result appears.
- With WATCH_BCD_BLANK_EN defined: year=7, month=1, day=1, hour=0, minute=0, second=0 → bcd_date = 0xFFF7_01_01_00_00_00; year=0 → year digits 0xFFF0.
- AUTO_RUN=1 with out_ready tied high and the inputs stepped each conversion → back-to-back results spaced 46 edges apart (start-accept edge, 44 conversion edges, handshake edge), each matching its own snapshot.
